pc_context_sched: RTL and testbench

Multi-context program counter with round-robin time-slice preemption for the MIPS core. Holds one saved PC per hardware context and drives the fetch address each cycle. Swaps the running context when its instruction quantum expires, or when it leaves its program. Generalises the single-context, fixed-10-instruction context-change PC to NUM_CTX contexts with a configurable quantum, explicit context loading and an idle state.

---
 rtl/pc_sched_pkg.sv | 20 ++
 rtl/rr_ctx_pick.sv | 36 +++
 rtl/pc_context_sched.sv | 169 ++++++++++++++++
 tb/tb_pc_context_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sched_pkg.sv
// pc_sched_pkg: shared types and defaults for the multi-context PC scheduler.
// Holds the scheduler state encoding, default geometry constants and the
// helper that derives the context-id width from the context count.
package pc_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam int unsigned PC_ADDR_W  = 32;
  localparam int unsigned PC_NUM_CTX = 4;
  localparam int unsigned PC_QUANTUM = 10;

  // Context-id width; a single-context build still needs one bit of id.
  function automatic int unsigned ctx_w_f(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_ctx_pick.sv
// rr_ctx_pick: combinational round-robin picker over the active-context mask.
// Searches upward from cur_id_i+1 with wrap; when excl_cur_i is set the
// current context itself is never returned (the search stops one short).
module rr_ctx_pick
  import pc_sched_pkg::*;
#(
  parameter int unsigned NUM_CTX = PC_NUM_CTX,
  parameter int unsigned CTX_W   = ctx_w_f(PC_NUM_CTX)
) (
  input  logic [NUM_CTX-1:0] active_i,
  input  logic [CTX_W-1:0]   cur_id_i,
  input  logic               excl_cur_i,
  output logic [CTX_W-1:0]   nxt_id_o,
  output logic               found_o
);

  // First active context after cur_id_i in wrap-around order.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    nxt_id_o = '0;
    found_o  = 1'b0;
    for (int unsigned k = 1; k <= NUM_CTX; k++) begin
      idx = 32'(cur_id_i) + k;
      if (idx >= NUM_CTX) begin
        idx = idx - NUM_CTX;
      end
      if (!found_o && active_i[idx[CTX_W-1:0]] &&
          !(excl_cur_i && (k == NUM_CTX))) begin
        found_o  = 1'b1;
        nxt_id_o = idx[CTX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pc_context_sched.sv
// pc_context_sched: multi-context program counter with round-robin
// time-slice preemption. One saved PC per hardware context; the running
// context is swapped on quantum expiry or when it leaves its program.
// Optional macro PC_SCHED_STALL_SWITCH_EN: a stall in RUN with another
// context active is treated as a quantum expiry (the stalled PC is saved).
module pc_context_sched
  import pc_sched_pkg::*;
#(
  parameter  int unsigned ADDR_W  = PC_ADDR_W,
  parameter  int unsigned NUM_CTX = PC_NUM_CTX,
  parameter  int unsigned QUANTUM = PC_QUANTUM,
  localparam int unsigned CTX_W   = ctx_w_f(NUM_CTX),
  localparam int unsigned SC_W    = $clog2(QUANTUM + 1)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              in_program,
  input  logic              ctx_load,
  input  logic [CTX_W-1:0]  ctx_load_id,
  input  logic [ADDR_W-1:0] ctx_load_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CTX_W-1:0]  ctx_id,
  output logic              ctx_switch,
  output logic              running,
  output logic [SC_W-1:0]   slice_count
);

  sched_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CTX_W-1:0]  id_q;
  logic              sw_q;
  logic              run_q;
  logic [SC_W-1:0]   sc_q;
  logic [ADDR_W-1:0] save_q [NUM_CTX];
  logic [NUM_CTX-1:0] active_q;

  logic [CTX_W-1:0]  pick_cur;
  logic              pick_excl;
  logic [CTX_W-1:0]  pick_id;
  logic              pick_found;

  logic              load_ok;
  logic              slice_end;
  logic              stall_hold;
  logic              stall_swap;
  logic              retire_go;

  // In IDLE search from NUM_CTX-1 so the lowest-numbered active context
  // wins; in RUN search after the running context and skip it.
  always_comb begin
    pick_cur  = (state_q == IDLE) ? CTX_W'(NUM_CTX - 1) : id_q;
    pick_excl = (state_q == RUN);
  end

  rr_ctx_pick #(
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W)
  ) u_pick (
    .active_i   (active_q),
    .cur_id_i   (pick_cur),
    .excl_cur_i (pick_excl),
    .nxt_id_o   (pick_id),
    .found_o    (pick_found)
  );

  // Load acceptance and slice-end detection.
  always_comb begin
    load_ok   = ctx_load && (32'(ctx_load_id) < NUM_CTX) &&
                !((state_q == RUN) && (ctx_load_id == id_q));
    slice_end = (sc_q == SC_W'(QUANTUM - 1));
  end

  // Stall handling: retire outranks the stall-switch, but a plain stall
  // freezes everything including retire.
`ifdef PC_SCHED_STALL_SWITCH_EN
  always_comb begin
    retire_go  = !in_program;
    stall_swap = stall && in_program && pick_found;
    stall_hold = stall && in_program && !pick_found;
  end
`else
  always_comb begin
    retire_go  = !stall && !in_program;
    stall_swap = 1'b0;
    stall_hold = stall;
  end
`endif

  // Scheduler FSM, saved-PC file and all registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      id_q     <= '0;
      sw_q     <= 1'b0;
      run_q    <= 1'b0;
      sc_q     <= '0;
      active_q <= '0;
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        save_q[i] <= '0;
      end
    end else begin
      sw_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            pc_q    <= save_q[pick_id];
            id_q    <= pick_id;
            sc_q    <= '0;
            sw_q    <= 1'b1;
            run_q   <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stall_hold) begin
            // frozen; only loads below may take effect
          end else if (stall_swap) begin
            save_q[id_q] <= pc_q;
            pc_q         <= save_q[pick_id];
            id_q         <= pick_id;
            sc_q         <= '0;
            sw_q         <= 1'b1;
          end else if (retire_go) begin
            active_q[id_q] <= 1'b0;
            sc_q           <= '0;
            if (pick_found) begin
              pc_q <= save_q[pick_id];
              id_q <= pick_id;
              sw_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              run_q   <= 1'b0;
            end
          end else if (slice_end) begin
            sc_q <= '0;
            if (pick_found) begin
              save_q[id_q] <= next_addr;
              pc_q         <= save_q[pick_id];
              id_q         <= pick_id;
              sw_q         <= 1'b1;
            end else begin
              pc_q <= next_addr;
            end
          end else begin
            pc_q <= next_addr;
            sc_q <= sc_q + SC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      // A load never targets the running context in RUN, so it cannot
      // collide with the save/active updates made above.
      if (load_ok) begin
        save_q[ctx_load_id]   <= ctx_load_addr;
        active_q[ctx_load_id] <= 1'b1;
      end
    end
  end

  assign pc_out      = pc_q;
  assign ctx_id      = id_q;
  assign ctx_switch  = sw_q;
  assign running     = run_q;
  assign slice_count = sc_q;

endmodule

// File: tb/tb_pc_context_sched.sv
// Scoreboard bench for pc_context_sched: the driver steps a behavioural
// scheduler model and queues the expected outputs; the monitor compares.
module tb_pc_context_sched;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned NUM_CTX = 4;
  localparam int unsigned QUANTUM = 10;
  localparam int unsigned CTX_W   = 2;
  localparam int unsigned SC_W    = 4;
`ifdef PC_SCHED_STALL_SWITCH_EN
  localparam bit SSW = 1'b1;
`else
  localparam bit SSW = 1'b0;
`endif

  logic              CLK;
  logic              reset;
  logic              stall;
  logic [ADDR_W-1:0] next_addr;
  logic              in_program;
  logic              ctx_load;
  logic [CTX_W-1:0]  ctx_load_id;
  logic [ADDR_W-1:0] ctx_load_addr;
  logic [ADDR_W-1:0] pc_out;
  logic [CTX_W-1:0]  ctx_id;
  logic              ctx_switch;
  logic              running;
  logic [SC_W-1:0]   slice_count;

  pc_context_sched #(
    .ADDR_W  (ADDR_W),
    .NUM_CTX (NUM_CTX),
    .QUANTUM (QUANTUM)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .stall         (stall),
    .next_addr     (next_addr),
    .in_program    (in_program),
    .ctx_load      (ctx_load),
    .ctx_load_id   (ctx_load_id),
    .ctx_load_addr (ctx_load_addr),
    .pc_out        (pc_out),
    .ctx_id        (ctx_id),
    .ctx_switch    (ctx_switch),
    .running       (running),
    .slice_count   (slice_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    int          id;
    bit          sw;
    bit          run;
    int          sc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: scheduler described by its rules, not its encoding.
  logic [31:0] m_save [NUM_CTX];
  bit          m_act  [NUM_CTX];
  logic [31:0] m_pc;
  int          m_id;
  int          m_sc;
  bit          m_sw;
  bit          m_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CTX; i++) begin
      m_save[i] = '0;
      m_act[i]  = 1'b0;
    end
    m_pc = '0; m_id = 0; m_sc = 0; m_sw = 1'b0; m_run = 1'b0;
  endfunction

  function automatic int pick(input int from, input bit excl);
    for (int k = 1; k <= NUM_CTX; k++) begin
      int c;
      c = (from + k) % NUM_CTX;
      if (excl && c == from) continue;
      if (m_act[c]) return c;
    end
    return -1;
  endfunction

  function automatic void go(input int n);
    m_pc = m_save[n];
    m_id = n;
    m_sc = 0;
    m_sw = 1'b1;
  endfunction

  function automatic void model_step(input bit st, input bit ip, input bit ld,
                                     input int lid, input logic [31:0] laddr,
                                     input logic [31:0] na);
    bit run0;
    int id0;
    int n;
    run0 = m_run;
    id0  = m_id;
    m_sw = 1'b0;
    if (!m_run) begin
      n = pick(NUM_CTX - 1, 1'b0);
      if (n >= 0) begin
        go(n);
        m_run = 1'b1;
      end
    end else if (st && !(SSW && !ip)) begin
      if (SSW) begin
        n = pick(m_id, 1'b1);
        if (n >= 0) begin
          m_save[m_id] = m_pc;
          go(n);
        end
      end
    end else if (!ip) begin
      m_act[m_id] = 1'b0;
      m_sc = 0;
      n = pick(m_id, 1'b1);
      if (n >= 0) go(n);
      else m_run = 1'b0;
    end else if (m_sc == QUANTUM - 1) begin
      m_sc = 0;
      n = pick(m_id, 1'b1);
      if (n >= 0) begin
        m_save[m_id] = na;
        go(n);
      end else begin
        m_pc = na;
      end
    end else begin
      m_pc = na;
      m_sc = m_sc + 1;
    end
    if (ld && !(run0 && lid == id0)) begin
      m_save[lid] = laddr;
      m_act[lid]  = 1'b1;
    end
  endfunction

  task automatic step(input bit st, input bit ip, input bit ld, input int lid,
                      input logic [31:0] laddr, input bit br);
    logic [31:0] na;
    exp_t e;
    @(negedge CLK);
    na = br ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
    stall         = st;
    in_program    = ip;
    ctx_load      = ld;
    ctx_load_id   = CTX_W'(lid);
    ctx_load_addr = laddr;
    next_addr     = na;
    model_step(st, ip, ld, lid, laddr, na);
    e.pc = m_pc; e.id = m_id; e.sw = m_sw; e.run = m_run; e.sc = m_sc;
    q.push_back(e);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc_out"},      pc_out,             32'h0);
    chk({tag, "_ctx_id"},      32'(ctx_id),        32'h0);
    chk({tag, "_ctx_switch"},  32'(ctx_switch),    32'h0);
    chk({tag, "_running"},     32'(running),       32'h0);
    chk({tag, "_slice_count"}, 32'(slice_count),   32'h0);
  endtask

  // Monitor: one expected record per clock edge, checked just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out",      pc_out,           e.pc);
        chk("ctx_id",      32'(ctx_id),      32'(e.id));
        chk("ctx_switch",  32'(ctx_switch),  32'(e.sw));
        chk("running",     32'(running),     32'(e.run));
        chk("slice_count", 32'(slice_count), 32'(e.sc));
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; stall = 1'b0; in_program = 1'b1; ctx_load = 1'b0;
    ctx_load_id = '0; ctx_load_addr = '0; next_addr = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    chk_zero("reset");

    // Single context: idle to run, then slice wrap without a pulse.
    step(1'b0, 1'b1, 1'b1, 0, 32'h100, 1'b0);
    run_n(25);
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    run_n(2);

    // Two contexts: ctx0@0x100, ctx1@0x400, quantum handoff and return.
    step(1'b0, 1'b1, 1'b1, 0, 32'h100, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1, 32'h400, 1'b0);
    run_n(10);
    @(posedge CLK); #2;
    chk("handoff_pc", pc_out, 32'h400);
    chk("handoff_id", 32'(ctx_id), 32'd1);
    chk("handoff_sw", 32'(ctx_switch), 32'd1);
    run_n(10);
    @(posedge CLK); #2;
    chk("return_pc", pc_out, 32'h128);
    chk("return_id", 32'(ctx_id), 32'd0);

    // Three contexts, ctx1 retires mid-slice.
    step(1'b0, 1'b1, 1'b1, 2, 32'h800, 1'b0);
    guard = 0;
    while (!(m_run && m_id == 1 && m_sc == 3) && guard < 60) begin
      run_n(1);
      guard++;
    end
    if (guard >= 60) begin errors++; checks++; $display("FAIL reach_ctx1: timeout"); end
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    run_n(45);

    // Retire everything, then restart from a load.
    guard = 0;
    while (m_run && guard < 10) begin
      step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
      guard++;
    end
    @(posedge CLK); #2;
    chk("idle_running", 32'(running), 32'd0);
    step(1'b0, 1'b1, 1'b1, 3, 32'h800, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    @(posedge CLK); #2;
    chk("restart_pc", pc_out, 32'h800);
    chk("restart_id", 32'(ctx_id), 32'd3);
    chk("restart_sw", 32'(ctx_switch), 32'd1);

    // Stall held at the last instruction of a slice, two contexts active.
    step(1'b0, 1'b1, 1'b1, 0, 32'h200, 1'b0);
    guard = 0;
    while (m_sc != QUANTUM - 1 && guard < 40) begin
      run_n(1);
      guard++;
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
    run_n(30);

    // Asynchronous reset during a switch cycle.
    guard = 0;
    while (!m_sw && guard < 40) begin
      run_n(1);
      guard++;
    end
    if (guard >= 40) begin errors++; checks++; $display("FAIL reach_switch: timeout"); end
    @(posedge CLK); #3;
    stall = 1'b0; in_program = 1'b1; ctx_load = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    model_reset();
    q.delete();
    @(negedge CLK);
    reset = 1'b0;
    run_n(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, NUM_CTX - 1)),
           ($urandom & 32'hFFFF_FFFC), ($urandom_range(0, 9) == 0));
    end

    @(posedge CLK); #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
